// File: rtl/seg7_capture.sv
// seg7_capture: debounces a 7-segment pattern bus, re-encodes it to a hex digit and
// queues accepted digits in a 2-entry valid/ready buffer. Optional macro: SEG7_CAPTURE_DP_EN.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
`ifdef SEG7_CAPTURE_DP_EN
    input  logic       seg_dp,
    output logic       out_dp,
`endif
    output logic [3:0] out_digit,
    output logic       out_invalid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

`ifdef SEG7_CAPTURE_DP_EN
    localparam int unsigned PW = 8;
    localparam int unsigned EW = 6;
`else
    localparam int unsigned PW = 7;
    localparam int unsigned EW = 5;
`endif

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_t;

    logic [PW-1:0] pat, samp, last;
    logic [CW-1:0] cnt;
    logic          accept, blank, push, pop;
    logic [EW-1:0] entry, head, tail;
    occ_t          occ, occ_nxt;
    logic          ld_head_in, ld_head_tail, ld_tail, set_ovf;

    function automatic logic [4:0] encode(input logic [6:0] p);
        case (p)
            7'h3F:   encode = 5'h00;
            7'h06:   encode = 5'h01;
            7'h5B:   encode = 5'h02;
            7'h4F:   encode = 5'h03;
            7'h66:   encode = 5'h04;
            7'h6D:   encode = 5'h05;
            7'h7D:   encode = 5'h06;
            7'h07:   encode = 5'h07;
            7'h7F:   encode = 5'h08;
            7'h6F:   encode = 5'h09;
            7'h77:   encode = 5'h0A;
            7'h7C:   encode = 5'h0B;
            7'h39:   encode = 5'h0C;
            7'h5E:   encode = 5'h0D;
            7'h79:   encode = 5'h0E;
            7'h71:   encode = 5'h0F;
            default: encode = 5'h10;
        endcase
    endfunction

`ifdef SEG7_CAPTURE_DP_EN
    assign pat   = {seg_dp, seg};
    assign entry = {samp[7], encode(samp[6:0])};
`else
    assign pat   = seg;
    assign entry = encode(samp);
`endif

    // A dp-only pattern still counts as blank: it updates last but is never queued.
    assign blank  = (samp[6:0] == 7'h00);
    assign accept = (pat == samp) && (cnt == CNT_PRE) && (samp != last);
    assign push   = accept && !blank;
    assign pop    = (occ != OCC_EMPTY) && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp <= '0;
            cnt  <= CNT_MAX;
            last <= '0;
        end else if (pat != samp) begin
            samp <= pat;
            cnt  <= '0;
        end else begin
            if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            if (accept)
                last <= samp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            occ <= OCC_EMPTY;
        else
            occ <= occ_nxt;
    end

    always_comb begin
        occ_nxt      = occ;
        ld_head_in   = 1'b0;
        ld_head_tail = 1'b0;
        ld_tail      = 1'b0;
        set_ovf      = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (push) begin
                    ld_head_in = 1'b1;
                    occ_nxt    = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    ld_head_in = 1'b1;
                end else if (push) begin
                    ld_tail = 1'b1;
                    occ_nxt = OCC_TWO;
                end else if (pop) begin
                    occ_nxt = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // When full, a simultaneous pop makes room so the push is kept.
                if (pop) begin
                    ld_head_tail = 1'b1;
                    if (push)
                        ld_tail = 1'b1;
                    else
                        occ_nxt = OCC_ONE;
                end else if (push) begin
                    set_ovf = 1'b1;
                end
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            overflow <= 1'b0;
        end else begin
            if (ld_head_in)
                head <= entry;
            else if (ld_head_tail)
                head <= tail;
            if (ld_tail)
                tail <= entry;
            if (set_ovf)
                overflow <= 1'b1;
        end
    end

    assign out_valid   = (occ != OCC_EMPTY);
    assign out_digit   = out_valid ? head[3:0] : '0;
    assign out_invalid = out_valid & head[4];
`ifdef SEG7_CAPTURE_DP_EN
    assign out_dp      = out_valid & head[5];
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Testbench for seg7_capture: directed plus random segment streams checked against
// a windowed-history reference model and a queue-based buffer model.
module tb_seg7_capture;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       out_ready = 1'b0;
    logic [6:0] seg = 7'h00;
    logic [3:0] out_digit;
    logic       out_invalid;
    logic       out_valid;
    logic       overflow;
`ifdef SEG7_CAPTURE_DP_EN
    logic       seg_dp = 1'b0;
    logic       out_dp;
`endif

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg        (seg),
`ifdef SEG7_CAPTURE_DP_EN
        .seg_dp     (seg_dp),
        .out_dp     (out_dp),
`endif
        .out_digit  (out_digit),
        .out_invalid(out_invalid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [6:0] hist[$];
    logic [4:0] q[$];
    logic [6:0] last_m;
    bit         ovf_m;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < int'(S) + 2; i++) hist.push_back(7'h00);
        q.delete();
        last_m = 7'h00;
        ovf_m  = 1'b0;
    endfunction

    function automatic logic [4:0] expect_entry(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (tab[i] == p) return {1'b0, 4'(i)};
        return 5'h10;
    endfunction

    // A pattern is accepted when the newest S+1 edge samples all equal it and the sample before differs.
    task automatic model_edge();
        bit         do_pop;
        bit         run;
        logic [6:0] p;
        if (reset) begin
            model_reset();
            return;
        end
        do_pop = (q.size() != 0) && out_ready;
        p = seg;
        hist.push_back(p);
        void'(hist.pop_front());
        run = 1'b1;
        for (int i = 1; i <= int'(S) + 1; i++)
            if (hist[i] != p) run = 1'b0;
        if (do_pop) void'(q.pop_front());
        if (run && hist[0] != p && p != last_m) begin
            last_m = p;
            if (p != 7'h00) begin
                if (q.size() < 2) q.push_back(expect_entry(p));
                else ovf_m = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (q.size() != 0);
        chk("out_valid", 8'(out_valid), 8'(ev));
        chk("out_digit", 8'(out_digit), ev ? 8'(q[0][3:0]) : 8'h00);
        chk("out_invalid", 8'(out_invalid), ev ? 8'(q[0][4]) : 8'h00);
        chk("overflow", 8'(overflow), 8'(ovf_m));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) tick();
    endtask

    initial begin
        logic [6:0] rp;
        int         len;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk("rst_valid", 8'(out_valid), 8'h00);
        chk("rst_digit", 8'(out_digit), 8'h00);
        chk("rst_ovf", 8'(overflow), 8'h00);
        reset = 1'b0;
        repeat (3) tick();

        // Basic encode and latency
        out_ready = 1'b1;
        seg = 7'h5B;
        repeat (4) begin
            tick();
            chk("lat_pre", 8'(out_valid), 8'h00);
        end
        tick();
        chk("lat_valid", 8'(out_valid), 8'h01);
        chk("lat_digit", 8'(out_digit), 8'h02);
        repeat (5) tick();

        // Glitch rejection
        hold(7'h06, 3);
        hold(7'h4F, 10);

        // Invalid and blank
        hold(7'h49, 8);
        hold(7'h00, 8);
        hold(7'h49, 8);

        // Repeat suppression
        hold(7'h7F, 20);
        hold(7'h00, 8);
        hold(7'h7F, 8);

        // Backpressure and overflow
        out_ready = 1'b0;
        hold(7'h06, 8);
        hold(7'h5B, 8);
        hold(7'h4F, 8);
        chk("bp_ovf", 8'(overflow), 8'h01);
        chk("bp_head1", 8'(out_digit), 8'h01);
        out_ready = 1'b1;
        tick();
        chk("bp_head2", 8'(out_digit), 8'h02);
        tick();
        chk("bp_empty", 8'(out_valid), 8'h00);
        chk("bp_ovf_sticky", 8'(overflow), 8'h01);

        // Full buffer with push and pop on the same edge
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        hold(7'h66, 8);
        hold(7'h6D, 8);
        seg = 7'h7D;
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        chk("pp_noovf", 8'(overflow), 8'h00);
        chk("pp_head", 8'(out_digit), 8'h05);
        repeat (4) tick();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        hold(7'h39, 6);
        hold(7'h5E, 6);
        hold(7'h79, 6);
        seg = 7'h71;
        repeat (2) tick();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("amid_valid", 8'(out_valid), 8'h00);
        chk("amid_digit", 8'(out_digit), 8'h00);
        chk("amid_inv", 8'(out_invalid), 8'h00);
        chk("amid_ovf", 8'(overflow), 8'h00);
        seg = 7'h00;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("no_spurious", 8'(out_valid), 8'h00);

        // Randomised streams with random consumer backpressure
        repeat (60) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rp = tab[$urandom_range(0, 15)];
                6, 7:             rp = 7'h00;
                default:          rp = 7'($urandom_range(1, 127));
            endcase
            len = int'($urandom_range(1, 10));
            seg = rp;
            repeat (len) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
